aoi_selftest_ctrl: RTL and testbench
====================================

Name: aoi_selftest_ctrl

Overview:
- Built-in self-test sequencer for the 4-input AND-OR-INVERT cell, y = ~((a & b) | (c & d)).
- On start, it drives all 16 input vectors {a,b,c,d} into the cell and waits a programmable settle time after each one.
- It then samples the cell output, compares it with an internal golden model, counts mismatches and latches the first failing vector.
- It sits beside the AOI instance and reports pass/fail to the system controller through a start/done handshake.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
- CNT_W, 5, width of the mismatch counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  cancel the sweep in progress; return to IDLE without asserting done.
- dut_y  input  1  output of the AOI cell under test.
- a, b, c, d  output  1 each  registered stimulus to the AOI cell.
- busy  output  1  high in APPLY and SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_cnt  output  CNT_W  mismatches in the current or last sweep, saturating.
- fail_valid  output  1  high once a mismatch has been recorded in the current or last sweep.
- first_fail_vec  output  4  {a,b,c,d} of the first mismatch; meaningful only when fail_valid=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, a=b=c=d=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail_vec=0, vec=0, settle counter=0.
- All outputs are registered.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - stimulus is driven to 0.
  - start=1 clears err_cnt, fail_valid, first_fail_vec and pass, sets vec=0, and moves to APPLY.
  - busy rises on the next edge.
- APPLY:
  - {a,b,c,d}=vec; the settle counter counts 0..SETTLE_CYCLES-1.
  - The state moves to SAMPLE on the edge where the counter equals SETTLE_CYCLES-1.
- SAMPLE (one cycle, stimulus unchanged):
  - expected = ~((vec[3]&vec[2]) | (vec[1]&vec[0])).
  - If dut_y != expected: err_cnt increments unless it is at its maximum.
  - If that mismatch occurs with fail_valid=0: first_fail_vec=vec and fail_valid=1.
  - If vec==15, go to DONE; otherwise vec=vec+1, counter=0, go to APPLY.
- DONE:
  - done=1 for exactly one cycle, busy=0, stimulus driven to 0.
  - pass is set to (err_cnt==0), using the value after the final SAMPLE.
  - Next state is IDLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles.
  - busy is high for 16*(SETTLE_CYCLES+1) cycles.
  - done is asserted in the cycle immediately after the last SAMPLE.
- start outside IDLE (including in DONE) is ignored.
- abort in APPLY or SAMPLE:
  - next state is IDLE with stimulus 0 and no done pulse.
  - err_cnt, fail_valid and first_fail_vec keep their partial values; pass stays 0.
  - abort takes priority over a SAMPLE comparison in the same cycle, so that cycle's mismatch is not counted.
  - abort in IDLE or DONE has no effect.
- Results (pass, err_cnt, fail_valid, first_fail_vec) are held until the next accepted start or reset.
- Reset mid-sweep returns everything to reset values immediately.

Test Plan:
- dut_y driven by a correct AOI model, SETTLE_CYCLES=2, pulse start:
  - busy is high for 48 cycles, then done is a 1-cycle pulse.
  - Result: pass=1, err_cnt=0, fail_valid=0.
  - Stimulus is 0000,0001,…,1111, each held 3 cycles.
- dut_y stuck at 0: pass=0, err_cnt=9, first_fail_vec=0000.
- dut_y stuck at 1: pass=0, err_cnt=7, first_fail_vec=0011.
- dut_y = inverted model:
  - with CNT_W=5: err_cnt=16 and first_fail_vec=0000.
  - with CNT_W=3: err_cnt saturates at 7.
- Correct model; start, then abort during vector 5; also pulse start while busy:
  - start while busy causes no restart.
  - abort returns to IDLE with no done and pass=0, and stimulus goes to 0 on the next edge.
  - A new start afterwards completes normally with pass=1.
- Drop rst_n mid-sweep (vector 9): all outputs go to reset values asynchronously, and the FSM stays in IDLE until the next start.

Source files
------------

// File: rtl/aoi_selftest_ctrl.sv
// Built-in self-test sequencer for a 4-input AND-OR-INVERT cell.
// Sweeps all 16 input vectors, holds each for SETTLE_CYCLES, samples the
// cell output against a golden model, and reports a saturating mismatch
// count plus the first failing vector through a start/done handshake.
module aoi_selftest_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,   // legal range 1..15
   parameter int unsigned CNT_W         = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_y,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [3:0]       first_fail_vec
);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ERR_MAX     = '1;

   state_t           state_q, state_d;
   logic [3:0]       vec_q, vec_d;
   logic [3:0]       settle_q, settle_d;
   logic [3:0]       stim_q, stim_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             fail_valid_q, fail_valid_d;
   logic [3:0]       first_fail_q, first_fail_d;
   logic             expected_y;

   // Golden AOI response for the vector currently applied.
   assign expected_y = ~((vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));

   // Next-state, result update and registered-output decode.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch;
      // blocking assignments here let later lines see err_d as already updated.
      state_d      = state_q;
      vec_d        = vec_q;
      settle_d     = settle_q;
      pass_d       = pass_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = APPLY;
               vec_d        = 4'd0;
               settle_d     = 4'd0;
               pass_d       = 1'b0;
               err_d        = '0;
               fail_valid_d = 1'b0;
               first_fail_d = 4'd0;
            end
         end
         APPLY: begin
            if (abort) begin
               state_d = IDLE;
            end else if (settle_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         SAMPLE: begin
            // Abort wins: the comparison of an aborted SAMPLE cycle is dropped.
            if (abort) begin
               state_d = IDLE;
            end else begin
               if (dut_y != expected_y) begin
                  if (err_q != ERR_MAX) err_d = err_q + CNT_W'(1);
                  if (!fail_valid_q) begin
                     fail_valid_d = 1'b1;
                     first_fail_d = vec_q;
                  end
               end
               if (vec_q == 4'd15) begin
                  state_d = DONE;
                  pass_d  = (err_d == '0);
               end else begin
                  state_d  = APPLY;
                  vec_d    = vec_q + 4'd1;
                  settle_d = 4'd0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so decode them from the state being entered.
      busy_d = (state_d == APPLY) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
      stim_d = busy_d ? vec_d : 4'd0;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: asynchronous reset clears every register, including results,
      // and sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         state_q      <= IDLE;
         vec_q        <= 4'd0;
         settle_q     <= 4'd0;
         stim_q       <= 4'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         first_fail_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         settle_q     <= settle_d;
         stim_q       <= stim_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign {a, b, c, d}   = stim_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_q;
   assign fail_valid     = fail_valid_q;
   assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_aoi_selftest_ctrl.sv
// Self-checking bench for aoi_selftest_ctrl. The AOI cell is modelled with a
// per-vector fault mask; expected results are derived from the mask alone.
module tb_aoi_selftest_ctrl;

   localparam int S0 = 2;   // settle cycles, main instance (CNT_W=5)
   localparam int S1 = 1;   // settle cycles, small instance (CNT_W=3)

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Main instance
   logic        start0, abort0, dut_y0, a0, b0, c0, d0, busy0, done0, pass0, fv0;
   logic [4:0]  err0;
   logic [3:0]  ff0;
   logic [15:0] mask0;

   // Small instance
   logic        start1, abort1, dut_y1, a1, b1, c1, d1, busy1, done1, pass1, fv1;
   logic [2:0]  err1;
   logic [3:0]  ff1;
   logic [15:0] mask1;

   // Cell model: true AOI response, flipped on vectors selected by the mask.
   assign dut_y0 = ~((a0 & b0) | (c0 & d0)) ^ mask0[{a0, b0, c0, d0}];
   assign dut_y1 = ~((a1 & b1) | (c1 & d1)) ^ mask1[{a1, b1, c1, d1}];

   aoi_selftest_ctrl #(.SETTLE_CYCLES(S0), .CNT_W(5)) u_main (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .dut_y(dut_y0),
      .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_valid(fv0), .first_fail_vec(ff0));

   aoi_selftest_ctrl #(.SETTLE_CYCLES(S1), .CNT_W(3)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_y(dut_y1),
      .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_valid(fv1), .first_fail_vec(ff1));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit aoi_of(input int v);
      return !((((v >> 3) & 1) == 1 && ((v >> 2) & 1) == 1) ||
               (((v >> 1) & 1) == 1 && (v & 1) == 1));
   endfunction

   // Mask reproducing an output stuck at 0 (flip wherever the cell should be 1).
   function automatic logic [15:0] stuck0_mask();
      logic [15:0] m = '0;
      for (int v = 0; v < 16; v++) m[v] = aoi_of(v);
      return m;
   endfunction

   function automatic int count_ones(input logic [15:0] m);
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m[i]);
      return n;
   endfunction

   function automatic int sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   function automatic logic [3:0] lowest(input logic [15:0] m);
      for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
      return 4'd0;
   endfunction

   // ---------------- directed procedures ----------------
   task automatic pulse_start0();
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
   endtask

   // Full sweep on the main instance; start is pulsed again in the DONE cycle.
   task automatic sweep0(input string tag, input logic [15:0] m);
      logic [3:0] seq[$];
      int         t = 0;
      int         bad = 0;
      int         n = count_ones(m);
      mask0 = m;
      pulse_start0();
      while (t < 200 && done0 !== 1'b1) begin
         if (busy0) seq.push_back({a0, b0, c0, d0});
         @(negedge clk);
         t++;
      end
      check({tag, "_done_seen"}, done0, 1'b1);
      check({tag, "_busy_len"}, seq.size(), 16 * (S0 + 1));
      for (int i = 0; i < seq.size(); i++) if (seq[i] != 4'(i / (S0 + 1))) bad++;
      check({tag, "_stim_seq"}, bad, 0);
      check({tag, "_busy_at_done"}, busy0, 1'b0);
      check({tag, "_stim_at_done"}, {a0, b0, c0, d0}, 4'd0);
      check({tag, "_pass"}, pass0, n == 0);
      check({tag, "_err_cnt"}, err0, sat(n, 31));
      check({tag, "_fail_valid"}, fv0, n != 0);
      check({tag, "_first_fail"}, ff0, lowest(m));
      start0 = 1'b1;                        // ignored in DONE
      @(negedge clk) start0 = 1'b0;
      check({tag, "_done_width"}, done0, 1'b0);
      check({tag, "_no_restart"}, busy0, 1'b0);
      check({tag, "_pass_held"}, pass0, n == 0);
   endtask

   // Abort at vector v (APPLY entry or its SAMPLE cycle); start pulsed at vector 2.
   task automatic abort0_run(input string tag, input int v, input bit in_sample,
                             input logic [15:0] m);
      int          t = 0;
      int          abort_t = v * (S0 + 1) + (in_sample ? S0 : 0);
      logic [15:0] seen = m & ((16'h1 << v) - 16'h1);
      int          dn = 0;
      mask0 = m;
      pulse_start0();
      while (t < abort_t) begin
         start0 = (t == 2 * (S0 + 1));
         @(negedge clk);
         t++;
      end
      start0 = 1'b0;
      check({tag, "_vec_at_abort"}, {a0, b0, c0, d0}, 4'(v));
      check({tag, "_busy_at_abort"}, busy0, 1'b1);
      abort0 = 1'b1;
      @(negedge clk) abort0 = 1'b0;
      check({tag, "_busy_off"}, busy0, 1'b0);
      check({tag, "_stim_zero"}, {a0, b0, c0, d0}, 4'd0);
      check({tag, "_pass"}, pass0, 1'b0);
      check({tag, "_err_cnt"}, err0, sat(count_ones(seen), 31));
      check({tag, "_fail_valid"}, fv0, seen != 0);
      check({tag, "_first_fail"}, ff0, lowest(seen));
      for (int i = 0; i < 3 * (S0 + 1); i++) begin
         dn += int'(done0 | busy0);
         @(negedge clk);
      end
      check({tag, "_stay_idle"}, dn, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] m;
      int          t;
      int          idle_bad;
      logic [3:0]  sq1[$];
      rst_n = 1'b0;
      {start0, abort0, start1, abort1} = '0;
      mask0 = '0;
      mask1 = 16'hFFFF;

      repeat (3) @(negedge clk);
      check("rst_stim", {a0, b0, c0, d0}, 4'd0);
      check("rst_flags", {busy0, done0, pass0, fv0}, 4'd0);
      check("rst_err", err0, 0);
      check("rst_ff", ff0, 4'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      sweep0("good", 16'h0000);
      sweep0("stuck0", stuck0_mask());
      sweep0("stuck1", ~stuck0_mask());
      sweep0("invert", 16'hFFFF);
      for (int k = 0; k < 4; k++) begin
         m = 16'($urandom);
         sweep0($sformatf("rand%0d", k), m);
      end

      // Narrow counter: inverted cell saturates at 7.
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      t = 0;
      while (t < 200 && done1 !== 1'b1) begin
         if (busy1) sq1.push_back({a1, b1, c1, d1});
         @(negedge clk);
         t++;
      end
      check("small_done_seen", done1, 1'b1);
      check("small_busy_len", sq1.size(), 16 * (S1 + 1));
      check("small_err_sat", err1, 3'd7);
      check("small_fail_valid", fv1, 1'b1);
      check("small_first_fail", ff1, 4'd0);
      check("small_pass", pass1, 1'b0);

      abort0_run("abort_apply", 5, 1'b0, 16'h0000);
      sweep0("after_abort", 16'h0000);
      m = 16'($urandom) | 16'h0020;
      abort0_run("abort_sample", 5, 1'b1, m);

      // Reset asserted during vector 9.
      m = 16'($urandom) | 16'h0001;
      mask0 = m;
      pulse_start0();
      t = 0;
      while (t < 9 * (S0 + 1) + 1) begin
         @(negedge clk);
         t++;
      end
      check("rst_mid_pre_vec", {a0, b0, c0, d0}, 4'd9);
      check("rst_mid_pre_err", err0, sat(count_ones(m & 16'h01FF), 31));
      rst_n = 1'b0;
      #1;
      check("rst_mid_stim", {a0, b0, c0, d0}, 4'd0);
      check("rst_mid_flags", {busy0, done0, pass0, fv0}, 4'd0);
      check("rst_mid_err", err0, 0);
      check("rst_mid_ff", ff0, 4'd0);
      @(negedge clk) rst_n = 1'b1;
      idle_bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         idle_bad += int'(busy0 | done0 | (|{a0, b0, c0, d0}));
      end
      check("rst_mid_stay_idle", idle_bad, 0);
      sweep0("after_reset", 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
